// File: rtl/cpu_path_sequencer.sv
// cpu_path_sequencer: holds the t2b CPU in reset, seeds the start and end nodes
// through the CPU's external write port, lets the CPU run while snooping its path
// stores, then streams the captured path out over valid/ready and parks the CPU.
//
// state  | meaning
// IDLE   | CPU parked in reset, waiting for start
// LOAD_S | external write of start node to START_ADDR
// LOAD_E | external write of end node to END_ADDR
// RUN    | CPU released; path stores captured, DONE store or timeout ends it
// DRAIN  | CPU parked again; captured path streamed out beat by beat
module cpu_path_sequencer #(
  parameter int          NODE_W     = 5,
  parameter int          MAX_PATH   = 32,
  parameter logic [31:0] START_ADDR = 32'h0200_0000,
  parameter logic [31:0] END_ADDR   = 32'h0200_0004,
  parameter logic [31:0] PATH_BASE  = 32'h0200_0008,
  parameter logic [31:0] DONE_ADDR  = 32'h0200_00FC,
  parameter int          TIMEOUT    = 200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NODE_W-1:0] start_node,
  input  logic [NODE_W-1:0] end_node,
  output logic              busy,
  output logic              cpu_reset,
  output logic              ext_memwrite,
  output logic [31:0]       ext_writedata,
  output logic [31:0]       ext_dataadr,
  input  logic              cpu_memwrite,
  input  logic [31:0]       cpu_writedata,
  input  logic [31:0]       cpu_dataadr,
  output logic              path_valid,
  input  logic              path_ready,
  output logic [NODE_W-1:0] path_node,
  output logic              path_last,
  output logic              done,
  output logic              timeout
);

  localparam int              IDX_W     = $clog2(MAX_PATH);
  localparam int              CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]      LEN_MAX   = 8'(MAX_PATH);
  localparam logic [31:0]     PATH_SPAN = 32'(4 * MAX_PATH);

  typedef enum logic [2:0] {IDLE, LOAD_S, LOAD_E, RUN, DRAIN} stateT;

  stateT stateQ, stateD;

  logic              cpuResetQ, cpuResetD;
  logic              busyQ, busyD;
  logic              extMemWriteQ, extMemWriteD;
  logic [31:0]       extWriteDataQ, extWriteDataD;
  logic [31:0]       extDataAdrQ, extDataAdrD;
  logic              pathValidQ, pathValidD;
  logic [NODE_W-1:0] pathNodeQ, pathNodeD;
  logic              pathLastQ, pathLastD;
  logic              doneQ, doneD;
  logic              timeoutQ, timeoutD;
  logic [NODE_W-1:0] endNodeQ, endNodeD;
  logic [7:0]        lenQ, lenD;
  logic [7:0]        idxQ, idxD;
  logic [CNT_W-1:0]  cntQ, cntD;

  logic [NODE_W-1:0] pathBuf [MAX_PATH];
  logic [31:0]       snoopOff;
  logic [IDX_W-1:0]  bufIdx;
  logic              bufWe;
  logic              doneHit;
  logic [7:0]        doneLen;
  logic [7:0]        idxNext;

  // upper store data carries nothing the sequencer captures
  logic unusedWriteData;
  assign unusedWriteData = ^cpu_writedata[31:8];

  // decode snooped stores: path slot address, DONE marker, clamped length
  always_comb begin
    snoopOff = cpu_dataadr - PATH_BASE;
    bufIdx   = snoopOff[IDX_W+1:2];
    bufWe    = (stateQ == RUN) && cpu_memwrite && (snoopOff[1:0] == 2'b00)
               && (snoopOff < PATH_SPAN);
    doneHit  = cpu_memwrite && (cpu_dataadr == DONE_ADDR);
    doneLen  = (cpu_writedata[7:0] > LEN_MAX) ? LEN_MAX : cpu_writedata[7:0];
    idxNext  = idxQ + 8'd1;
  end

  // path buffer; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (bufWe) pathBuf[bufIdx] <= cpu_writedata[NODE_W-1:0];
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // next state and next registered outputs
  always_comb begin
    stateD        = stateQ;
    cpuResetD     = 1'b1;
    extMemWriteD  = 1'b0;
    extWriteDataD = '0;
    extDataAdrD   = '0;
    pathValidD    = 1'b0;
    pathNodeD     = pathNodeQ;
    pathLastD     = 1'b0;
    doneD         = 1'b0;
    timeoutD      = timeoutQ;
    endNodeD      = endNodeQ;
    lenD          = lenQ;
    idxD          = idxQ;
    cntD          = cntQ;
    unique case (stateQ)
      IDLE: begin
        if (start) begin
          stateD        = LOAD_S;
          timeoutD      = 1'b0;
          endNodeD      = end_node;
          extMemWriteD  = 1'b1;
          extDataAdrD   = START_ADDR;
          extWriteDataD = {{(32-NODE_W){1'b0}}, start_node};
        end
      end
      LOAD_S: begin
        stateD        = LOAD_E;
        extMemWriteD  = 1'b1;
        extDataAdrD   = END_ADDR;
        extWriteDataD = {{(32-NODE_W){1'b0}}, endNodeQ};
      end
      LOAD_E: begin
        stateD    = RUN;
        cpuResetD = 1'b0;
        cntD      = '0;
      end
      RUN: begin
        // a DONE store on the limit cycle still counts as a finished job
        if (doneHit) begin
          stateD     = DRAIN;
          lenD       = doneLen;
          idxD       = '0;
          pathValidD = (doneLen != 8'd0);
          pathNodeD  = pathBuf[0];
          pathLastD  = (doneLen == 8'd1);
        end else if (cntQ == CNT_LAST) begin
          stateD   = IDLE;
          timeoutD = 1'b1;
          doneD    = 1'b1;
        end else begin
          cpuResetD = 1'b0;
          cntD      = cntQ + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!pathValidQ) begin
          stateD = IDLE;
          doneD  = 1'b1;
        end else if (path_ready) begin
          if (pathLastQ) begin
            stateD = IDLE;
            doneD  = 1'b1;
          end else begin
            idxD       = idxNext;
            pathValidD = 1'b1;
            pathNodeD  = pathBuf[idxNext[IDX_W-1:0]];
            pathLastD  = (idxNext == lenQ - 8'd1);
          end
        end else begin
          pathValidD = 1'b1;
          pathLastD  = pathLastQ;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign busyD = (stateD != IDLE);

  // output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpuResetQ     <= 1'b1;
      busyQ         <= 1'b0;
      extMemWriteQ  <= 1'b0;
      extWriteDataQ <= '0;
      extDataAdrQ   <= '0;
      pathValidQ    <= 1'b0;
      pathNodeQ     <= '0;
      pathLastQ     <= 1'b0;
      doneQ         <= 1'b0;
      timeoutQ      <= 1'b0;
      endNodeQ      <= '0;
      lenQ          <= '0;
      idxQ          <= '0;
      cntQ          <= '0;
    end else begin
      cpuResetQ     <= cpuResetD;
      busyQ         <= busyD;
      extMemWriteQ  <= extMemWriteD;
      extWriteDataQ <= extWriteDataD;
      extDataAdrQ   <= extDataAdrD;
      pathValidQ    <= pathValidD;
      pathNodeQ     <= pathNodeD;
      pathLastQ     <= pathLastD;
      doneQ         <= doneD;
      timeoutQ      <= timeoutD;
      endNodeQ      <= endNodeD;
      lenQ          <= lenD;
      idxQ          <= idxD;
      cntQ          <= cntD;
    end
  end

  assign cpu_reset     = cpuResetQ;
  assign busy          = busyQ;
  assign ext_memwrite  = extMemWriteQ;
  assign ext_writedata = extWriteDataQ;
  assign ext_dataadr   = extDataAdrQ;
  assign path_valid    = pathValidQ;
  assign path_node     = pathNodeQ;
  assign path_last     = pathLastQ;
  assign done          = doneQ;
  assign timeout       = timeoutQ;

endmodule

// File: tb/tb_cpu_path_sequencer.sv
// Bench for cpu_path_sequencer: drives jobs through start, snooped CPU stores and
// the path port, and compares against a plain array model of the path buffer.
module tb_cpu_path_sequencer;
  localparam int          NODE_W     = 5;
  localparam int          MAX_PATH   = 32;
  localparam int          TMO        = 16;
  localparam logic [31:0] START_ADDR = 32'h0200_0000;
  localparam logic [31:0] END_ADDR   = 32'h0200_0004;
  localparam logic [31:0] PATH_BASE  = 32'h0200_0008;
  localparam logic [31:0] DONE_ADDR  = 32'h0200_00FC;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NODE_W-1:0] start_node, end_node;
  logic              busy, cpu_reset, ext_memwrite;
  logic [31:0]       ext_writedata, ext_dataadr;
  logic              cpu_memwrite;
  logic [31:0]       cpu_writedata, cpu_dataadr;
  logic              path_valid, path_ready, path_last, done, timeout;
  logic [NODE_W-1:0] path_node;

  cpu_path_sequencer #(
    .NODE_W(NODE_W), .MAX_PATH(MAX_PATH), .START_ADDR(START_ADDR),
    .END_ADDR(END_ADDR), .PATH_BASE(PATH_BASE), .DONE_ADDR(DONE_ADDR), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_node(start_node),
    .end_node(end_node), .busy(busy), .cpu_reset(cpu_reset),
    .ext_memwrite(ext_memwrite), .ext_writedata(ext_writedata),
    .ext_dataadr(ext_dataadr), .cpu_memwrite(cpu_memwrite),
    .cpu_writedata(cpu_writedata), .cpu_dataadr(cpu_dataadr),
    .path_valid(path_valid), .path_ready(path_ready), .path_node(path_node),
    .path_last(path_last), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [NODE_W-1:0] bufModel [MAX_PATH];
  bit          qEn[$];
  logic [31:0] qAdr[$];
  logic [31:0] qData[$];
  int pat[5] = '{1, 0, 0, 1, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // a store lands in slot k only if it is word k of the path area
  function automatic void modelStore(logic [31:0] adr, logic [31:0] data);
    longint off;
    off = longint'(adr) - longint'(PATH_BASE);
    if (off >= 0 && off % 4 == 0 && off / 4 < MAX_PATH)
      bufModel[int'(off / 4)] = data[NODE_W-1:0];
  endfunction

  function automatic void pushWr(bit en, logic [31:0] adr, logic [31:0] data);
    qEn.push_back(en);
    qAdr.push_back(adr);
    qData.push_back(data);
  endfunction

  task automatic startJob(input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] e);
    start = 1'b1; start_node = s; end_node = e;
    tick();
    start = 1'b0; start_node = NODE_W'($urandom); end_node = NODE_W'($urandom);
    vectors++;
    if (ext_memwrite !== 1'b1 || ext_dataadr !== START_ADDR || ext_writedata !== 32'(s)
        || cpu_reset !== 1'b1 || busy !== 1'b1 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL load_s: we=%0b adr=%h data=%h crst=%0b busy=%0b tmo=%0b, want 1 %h %h 1 1 0",
               ext_memwrite, ext_dataadr, ext_writedata, cpu_reset, busy, timeout, START_ADDR, 32'(s));
    end
    tick();
    vectors++;
    if (ext_memwrite !== 1'b1 || ext_dataadr !== END_ADDR || ext_writedata !== 32'(e)
        || cpu_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL load_e: we=%0b adr=%h data=%h crst=%0b, want 1 %h %h 1",
               ext_memwrite, ext_dataadr, ext_writedata, cpu_reset, END_ADDR, 32'(e));
    end
    tick();
    vectors++;
    if (cpu_reset !== 1'b0 || ext_memwrite !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL run_entry: crst=%0b we=%0b busy=%0b, want 0 0 1", cpu_reset, ext_memwrite, busy);
    end
  endtask

  // full job: start, queued stores, DONE store, drain under a ready policy
  task automatic runJob(input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] e,
                        input logic [7:0] doneVal, input int readyMode, input bit pokeStart);
    int L, got, cyc;
    bit rdy, prevStall;
    logic [NODE_W-1:0] prevNode;
    logic prevLast;
    startJob(s, e);
    while (qEn.size() > 0) begin
      cpu_memwrite  = qEn.pop_front();
      cpu_dataadr   = qAdr.pop_front();
      cpu_writedata = qData.pop_front();
      if (pokeStart) begin
        start = 1'b1; start_node = NODE_W'($urandom); end_node = NODE_W'($urandom);
      end
      if (cpu_memwrite) modelStore(cpu_dataadr, cpu_writedata);
      tick();
      vectors++;
      if (cpu_reset !== 1'b0 || ext_memwrite !== 1'b0 || busy !== 1'b1 || path_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL run_hold: crst=%0b we=%0b busy=%0b pv=%0b, want 0 0 1 0",
                 cpu_reset, ext_memwrite, busy, path_valid);
      end
    end
    start = 1'b0;
    cpu_memwrite = 1'b1; cpu_dataadr = DONE_ADDR; cpu_writedata = {24'($urandom), doneVal};
    L = (int'(doneVal) > MAX_PATH) ? MAX_PATH : int'(doneVal);
    tick();
    cpu_memwrite = 1'b0; cpu_dataadr = 32'($urandom); cpu_writedata = 32'($urandom);
    vectors++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1 || timeout !== 1'b0 || path_valid !== (L != 0)) begin
      miscompares++;
      $display("FAIL drain_entry: crst=%0b busy=%0b tmo=%0b pv=%0b, want 1 1 0 %0b",
               cpu_reset, busy, timeout, path_valid, (L != 0));
    end
    if (L == 0) begin
      tick();
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || path_valid !== 1'b0 || cpu_reset !== 1'b1) begin
        miscompares++;
        $display("FAIL done_len0: done=%0b busy=%0b pv=%0b crst=%0b, want 1 0 0 1",
                 done, busy, path_valid, cpu_reset);
      end
    end else begin
      got = 0; cyc = 0; prevStall = 1'b0; prevNode = '0; prevLast = 1'b0;
      while (got < L && cyc < 400) begin
        vectors++;
        if (path_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL beat_valid: pv=%0b at beat %0d, want 1", path_valid, got);
          break;
        end
        if (prevStall) begin
          vectors++;
          if (path_node !== prevNode || path_last !== prevLast) begin
            miscompares++;
            $display("FAIL stall_hold: node=%0d last=%0b, want %0d %0b",
                     path_node, path_last, prevNode, prevLast);
          end
        end
        case (readyMode)
          0:       rdy = 1'b1;
          1:       rdy = (pat[cyc % 5] != 0);
          default: rdy = ($urandom_range(0, 1) != 0);
        endcase
        path_ready = rdy;
        if (rdy) begin
          vectors++;
          if (path_node !== bufModel[got] || path_last !== (got == L - 1)) begin
            miscompares++;
            $display("FAIL beat: idx=%0d node=%0d last=%0b, want %0d %0b",
                     got, path_node, path_last, bufModel[got], (got == L - 1));
          end
          got++;
        end
        prevStall = !rdy; prevNode = path_node; prevLast = path_last;
        tick();
        cyc++;
      end
      path_ready = 1'b0;
      vectors++;
      if (got != L) begin
        miscompares++;
        $display("FAIL beat_count: got %0d beats, want %0d", got, L);
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || path_valid !== 1'b0 || cpu_reset !== 1'b1) begin
        miscompares++;
        $display("FAIL drain_done: done=%0b busy=%0b pv=%0b crst=%0b, want 1 0 0 1",
                 done, busy, path_valid, cpu_reset);
      end
      if (readyMode == 0) begin
        vectors++;
        if (cyc != L) begin
          miscompares++;
          $display("FAIL throughput: %0d cycles for %0d beats, want %0d", cyc, L, L);
        end
      end
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%0b busy=%0b, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; start_node = '0; end_node = '0;
    cpu_memwrite = 1'b0; cpu_writedata = '0; cpu_dataadr = '0; path_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (cpu_reset !== 1'b1 || busy !== 1'b0 || ext_memwrite !== 1'b0 || ext_writedata !== 32'd0
        || ext_dataadr !== 32'd0 || path_valid !== 1'b0 || path_last !== 1'b0
        || path_node !== '0 || done !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: crst=%0b busy=%0b we=%0b wd=%h adr=%h pv=%0b pl=%0b pn=%0d done=%0b tmo=%0b",
               cpu_reset, busy, ext_memwrite, ext_writedata, ext_dataadr, path_valid,
               path_last, path_node, done, timeout);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_hold: busy=%0b crst=%0b, want 0 1", busy, cpu_reset);
    end
  endtask

  // seed every slot with known data over three zero-length jobs
  task automatic test_fill();
    for (int j = 0; j < 3; j++) begin
      for (int k = j * 11; k < ((j == 2) ? MAX_PATH : j * 11 + 11); k++)
        pushWr(1'b1, PATH_BASE + 32'(4 * k), $urandom);
      runJob(NODE_W'($urandom), NODE_W'($urandom), 8'd0, 0, j == 1);
    end
  endtask

  task automatic test_basic();
    pushWr(1'b1, PATH_BASE + 32'd0, 32'd3);
    pushWr(1'b1, PATH_BASE + 32'd4, 32'd5);
    pushWr(1'b1, PATH_BASE + 32'd8, 32'd9);
    runJob(5'd3, 5'd9, 8'd3, 0, 1'b0);
  endtask

  task automatic test_stall();
    pushWr(1'b1, PATH_BASE + 32'd0, 32'd3);
    pushWr(1'b1, PATH_BASE + 32'd4, 32'd5);
    pushWr(1'b1, PATH_BASE + 32'd8, 32'd9);
    runJob(5'd3, 5'd9, 8'd3, 1, 1'b0);
  endtask

  task automatic test_boundaries();
    pushWr(1'b1, PATH_BASE + 32'(4 * MAX_PATH), 32'h1F);
    pushWr(1'b1, PATH_BASE + 32'(4 * 5 + 2), $urandom);
    pushWr(1'b1, START_ADDR, $urandom);
    pushWr(1'b0, PATH_BASE + 32'(4 * 7), $urandom);
    pushWr(1'b1, PATH_BASE + 32'(4 * (MAX_PATH - 1)), $urandom);
    runJob(NODE_W'($urandom), NODE_W'($urandom), 8'd200, 2, 1'b0);
  endtask

  task automatic test_idle_snoop();
    for (int i = 0; i < 4; i++) begin
      cpu_memwrite = 1'b1; cpu_dataadr = PATH_BASE + 32'(4 * i); cpu_writedata = $urandom;
      tick();
    end
    cpu_memwrite = 1'b0;
    runJob(NODE_W'($urandom), NODE_W'($urandom), 8'd32, 0, 1'b0);
  endtask

  task automatic test_timeout();
    startJob(NODE_W'($urandom), NODE_W'($urandom));
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      vectors++;
      if (cpu_reset !== 1'b0 || path_valid !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL tmo_run: cycle %0d crst=%0b pv=%0b done=%0b, want 0 0 0",
                 i + 1, cpu_reset, path_valid, done);
      end
    end
    tick();
    vectors++;
    if (done !== 1'b1 || timeout !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1 || path_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_abort: done=%0b tmo=%0b busy=%0b crst=%0b pv=%0b, want 1 1 0 1 0",
               done, timeout, busy, cpu_reset, path_valid);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_sticky: done=%0b tmo=%0b, want 0 1", done, timeout);
    end
    runJob(NODE_W'($urandom), NODE_W'($urandom), 8'd0, 0, 1'b0);
  endtask

  task automatic test_done_at_limit();
    for (int i = 0; i < TMO - 1; i++)
      pushWr(i == 6, PATH_BASE + 32'(4 * 1), $urandom);
    runJob(NODE_W'($urandom), NODE_W'($urandom), 8'd4, 2, 1'b0);
  endtask

  task automatic test_random();
    int n, sel;
    logic [7:0] dv;
    for (int j = 0; j < 15; j++) begin
      n = $urandom_range(0, TMO - 1);
      for (int i = 0; i < n; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)       pushWr($urandom_range(0, 3) != 0, PATH_BASE + 32'(4 * $urandom_range(0, MAX_PATH - 1)), $urandom);
        else if (sel == 7) pushWr(1'b1, PATH_BASE + 32'(4 * (MAX_PATH + $urandom_range(0, 19))), $urandom);
        else if (sel == 8) pushWr(1'b1, PATH_BASE + 32'(4 * $urandom_range(0, MAX_PATH - 1) + $urandom_range(1, 3)), $urandom);
        else               pushWr(1'b1, 32'h1000_0000 + 32'(4 * $urandom_range(0, 1000)), $urandom);
      end
      case ($urandom_range(0, 3))
        0:       dv = 8'd200;
        1:       dv = 8'($urandom_range(33, 255));
        default: dv = 8'($urandom_range(0, 40));
      endcase
      runJob(NODE_W'($urandom), NODE_W'($urandom), dv, 2, $urandom_range(0, 1) != 0);
    end
  endtask

  task automatic test_reset_mid_run();
    startJob(NODE_W'($urandom), NODE_W'($urandom));
    cpu_memwrite = 1'b1; cpu_dataadr = PATH_BASE; cpu_writedata = $urandom;
    tick();
    cpu_memwrite = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (cpu_reset !== 1'b1 || busy !== 1'b0 || path_valid !== 1'b0 || ext_memwrite !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_run: crst=%0b busy=%0b pv=%0b we=%0b done=%0b, want 1 0 0 0 0",
               cpu_reset, busy, path_valid, ext_memwrite, done);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_run_idle: busy=%0b crst=%0b, want 0 1", busy, cpu_reset);
    end
  endtask

  task automatic test_reset_mid_drain();
    startJob(NODE_W'($urandom), NODE_W'($urandom));
    cpu_memwrite = 1'b1; cpu_dataadr = DONE_ADDR; cpu_writedata = 32'd5;
    path_ready = 1'b0;
    tick();
    cpu_memwrite = 1'b0;
    tick();
    vectors++;
    if (path_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_stalled: pv=%0b busy=%0b, want 1 1", path_valid, busy);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (path_valid !== 1'b0 || path_last !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_drain: pv=%0b pl=%0b crst=%0b busy=%0b, want 0 0 1 0",
               path_valid, path_last, cpu_reset, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_stall();
    test_boundaries();
    test_idle_snoop();
    test_timeout();
    test_done_at_limit();
    test_random();
    test_reset_mid_drain();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
